// File: rtl/divider_16bit_seq.sv
// Iterative restoring divider for the execute stage.
// Unsigned and signed (two's-complement) divide/remainder with RISC-V
// DIV/DIVU/REM/REMU results, including divide-by-zero and overflow cases.
// One shift-and-subtract step per cycle. Latency is fixed: if start is
// accepted at edge k, valid rises just after edge k+WIDTH+1, so valid is high
// when edge k+WIDTH+2 samples it.
//
// Handshake: a request is taken on any rising edge where start & ready.
// ready is high in IDLE and DONE. valid is high only in DONE.
// quotient, remainder and the flags are registered. They change only on the
// SIGN->DONE edge or at reset, and hold until the next request is accepted.
// start is ignored while ready is low.
module divider_16bit_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
    logic [WIDTH-1:0] dq_q, dq_d;            // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dmag_q, dmag_d;        // divisor magnitude
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;  // original dividend, returned as the remainder on /0
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, dmag_ext, trial;
    logic [WIDTH+1:0] sub_sum;
    logic             no_borrow;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Operand magnitudes at accept. Both are negated only for signed operands.
    // The most-negative value stays unchanged and is read as unsigned.
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        if (is_signed && dividend[WIDTH-1]) dvd_mag = ~dividend + WIDTH'(1);
        if (is_signed && divisor[WIDTH-1])  dvs_mag = ~divisor + WIDTH'(1);
    end

    // One restoring step: shift {rem, dq} left, then compute rem - divisor
    // as A + ~B + 1 on WIDTH+1 bits. A carry out means the subtract did not borrow.
    always_comb begin
        rem_sh    = {rem_q, dq_q[WIDTH-1]};
        dmag_ext  = {1'b0, dmag_q};
        sub_sum   = {1'b0, rem_sh} + {1'b0, ~dmag_ext} + {{(WIDTH+1){1'b0}}, 1'b1};
        trial     = sub_sum[WIDTH:0];
        no_borrow = sub_sum[WIDTH+1];
    end

    // Apply the result signs to the unsigned quotient and remainder.
    always_comb begin
        q_fix = q_neg_q ? (~dq_q + WIDTH'(1)) : dq_q;
        r_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    // Next-state logic, datapath updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        dq_d          = dq_q;
        dmag_d        = dmag_q;
        dvd_raw_d     = dvd_raw_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_pend_d    = dbz_pend_q;
        ovf_pend_d    = ovf_pend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        ready         = (state_q == S_IDLE) || (state_q == S_DONE);
        valid         = (state_q == S_DONE);
        accept        = start && ready;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d    = S_CALC;
                    cnt_d      = '0;
                    rem_d      = '0;
                    dq_d       = dvd_mag;
                    dmag_d     = dvs_mag;
                    dvd_raw_d  = dividend;
                    q_neg_d    = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d    = is_signed && dividend[WIDTH-1];
                    dbz_pend_d = (divisor == '0);
                    ovf_pend_d = is_signed && (dividend == MOST_NEG) && (divisor == ALL_ONES);
                end
            end
            S_CALC: begin
                rem_d = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                dq_d  = {dq_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_SIGN;
            end
            S_SIGN: begin
                state_d = S_DONE;
                if (dbz_pend_q) begin
                    quotient_d    = ALL_ONES;
                    remainder_d   = dvd_raw_q;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else if (ovf_pend_q) begin
                    quotient_d    = MOST_NEG;
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b1;
                end else begin
                    quotient_d    = q_fix;
                    remainder_d   = r_fix;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            dq_q          <= '0;
            dmag_q        <= '0;
            dvd_raw_q     <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_pend_q    <= 1'b0;
            ovf_pend_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            dq_q          <= dq_d;
            dmag_q        <= dmag_d;
            dvd_raw_q     <= dvd_raw_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_pend_q    <= dbz_pend_d;
            ovf_pend_q    <= ovf_pend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_divider_16bit_seq.sv
// Directed bench for divider_16bit_seq.
// The expected quotient, remainder, flags and latency are computed by hand.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_divider_16bit_seq;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        valid;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    divider_16bit_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // Scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] exp_q[$];   // {quotient, remainder, div_by_zero, overflow}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    // Counts edges after the accept edge until valid is seen at a falling edge.
    // It then adds one, because the next rising edge is the first one to see valid.
    // poke pulses start with random operands while the divider is busy.
    task automatic wait_done(input string name, input bit poke, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 8) check({name, "_ready_busy"}, 32'(ready), 32'd0);
            if (poke && lat == 5) begin
                start     = 1'b1;
                is_signed = 1'($urandom_range(0, 1));
                dividend  = 16'($urandom_range(0, 16'hFFFF));
                divisor   = 16'($urandom_range(0, 16'hFFFF));
            end else if (poke && lat == 6) begin
                start = 1'b0;
            end
        end while (!valid && lat < 40);
        lat = lat + 1;
    endtask

    task automatic check_result(input string name, input int lat);
        logic [33:0] e;
        e = exp_q.pop_front();
        check({name, "_latency"}, 32'(lat), 32'd18);
        check({name, "_quotient"}, 32'(quotient), 32'(e[33:18]));
        check({name, "_remainder"}, 32'(remainder), 32'(e[17:2]));
        check({name, "_div_by_zero"}, 32'(div_by_zero), 32'(e[1]));
        check({name, "_overflow"}, 32'(overflow), 32'(e[0]));
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic [15:0] eq, input logic [15:0] er,
                          input logic ed, input logic eo, input bit poke);
        int lat;
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        exp_q.push_back({eq, er, ed, eo});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, "_valid_low"}, 32'(valid), 32'd0);
        wait_done(name, poke, lat);
        check_result(name, lat);
    endtask

    // Stimulus
    initial begin
        int lat;
        int vhigh;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst_n = 1'b1;

        run_op("u100_7",   16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("sm100_7",  16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("s100_m7",  16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("dz_u",     16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0);
        run_op("dz_s",     16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0);
        run_op("ovf_s",    16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_u",    16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0);
        run_op("sm7_m2",   16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("poke_u",   16'hFFFF, 16'h00FF, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b1);

        // DONE holds its results while no start arrives
        repeat (3) @(negedge clk);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_quotient", 32'(quotient), 32'h0101);

        // Back-to-back: start stays high, and the second request is taken on the edge that leaves DONE
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'hFFFF;
        divisor   = 16'h0001;
        exp_q.push_back({16'hFFFF, 16'h0000, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        dividend = 16'h0010;
        divisor  = 16'h0003;
        exp_q.push_back({16'h0005, 16'h0001, 1'b0, 1'b0});
        wait_done("b2b_first", 1'b0, lat);
        check_result("b2b_first", lat);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_one_cycle_valid", 32'(valid), 32'd0);
        check("b2b_one_cycle_ready", 32'(ready), 32'd0);
        wait_done("b2b_second", 1'b0, lat);
        check_result("b2b_second", lat);

        // Reset in the middle of CALC throws the operation away
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'h7777;
        divisor   = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst_n = 1'b1;
        vhigh = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) vhigh++;
        end
        check("midrst_no_valid", 32'(vhigh), 32'd0);
        run_op("after_rst_9_3", 16'h0009, 16'h0003, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
